// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage with its IF/ID pipeline register. It owns the program
// counter, presents the PC to instruction memory (combinational read), and
// latches the returned word together with its PC into IF/ID for the decoder.
// The hazard unit can stall the stage, and the execute stage can redirect it
// (which also flushes IF/ID). Fetching a HLT opcode parks the stage in HALT
// until a redirect arrives.
//
// Ports:
//   clk              system clock, rising edge
//   reset            synchronous, active-high reset
//   o_imem_addr      fetch address (current PC) to instruction memory
//   i_imem_data      instruction word read at o_imem_addr this cycle
//   i_stall          hold PC, IF/ID, state and counter
//   i_branch_taken   redirect fetch to i_branch_target and flush IF/ID
//   i_branch_target  redirect address, meaningful only with i_branch_taken
//   o_instr          IF/ID instruction word
//   o_pc             PC of o_instr
//   o_pc_plus1       o_pc + 1 (wraps), used for branch offsets
//   o_valid          o_instr is a real fetched instruction, not a bubble
//   o_halted         stage is in HALT
//   o_fetch_count    saturating count of valid words latched into IF/ID
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [3:0]          NOP_OPCODE  = 4'b1100,
    parameter logic [3:0]          HLT_OPCODE  = 4'b1111
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [PC_WIDTH-1:0]    o_imem_addr,
    input  logic [INSTR_WIDTH-1:0] i_imem_data,
    input  logic                   i_stall,
    input  logic                   i_branch_taken,
    input  logic [PC_WIDTH-1:0]    i_branch_target,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [PC_WIDTH-1:0]    o_pc,
    output logic [PC_WIDTH-1:0]    o_pc_plus1,
    output logic                   o_valid,
    output logic                   o_halted,
    output logic [15:0]            o_fetch_count
);

    localparam logic [INSTR_WIDTH-1:0] NOP_WORD =
        {NOP_OPCODE, {(INSTR_WIDTH-4){1'b0}}};

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end
        return value + 16'd1;
    endfunction

    // PC increment; wrapping past the top of the address space is intended.
    function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] value);
        return value + PC_WIDTH'(1);
    endfunction

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_p0, pc_p0_d;
    logic [INSTR_WIDTH-1:0] instr_p1, instr_p1_d;
    logic [PC_WIDTH-1:0]    pc_p1, pc_p1_d;
    logic                   vld_p1, vld_p1_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   is_hlt;

    assign is_hlt = (i_imem_data[INSTR_WIDTH-1 -: 4] == HLT_OPCODE);

    // Next-state and IF/ID load selection. Branch wins over stall; a stall
    // simply leaves every default (hold) in place.
    always_comb begin
        state_d    = state_q;
        pc_p0_d    = pc_p0;
        instr_p1_d = instr_p1;
        pc_p1_d    = pc_p1;
        vld_p1_d   = vld_p1;
        cnt_d      = cnt_q;

        if (i_branch_taken) begin
            // The word read this cycle belongs to the wrong path; drop it.
            pc_p0_d    = i_branch_target;
            instr_p1_d = NOP_WORD;
            pc_p1_d    = '0;
            vld_p1_d   = 1'b0;
            state_d    = ST_RUN;
        end else if (!i_stall) begin
            case (state_q)
                ST_RUN: begin
                    instr_p1_d = i_imem_data;
                    pc_p1_d    = pc_p0;
                    vld_p1_d   = 1'b1;
                    cnt_d      = sat_inc16(cnt_q);
                    // HLT is passed down as a real instruction, but the PC
                    // stays on it so a resume only happens via redirect.
                    if (is_hlt) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_p0_d = pc_inc(pc_p0);
                    end
                end
                ST_HALT: begin
                    instr_p1_d = NOP_WORD;
                    pc_p1_d    = '0;
                    vld_p1_d   = 1'b0;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // ---- Stage boundary: PC (p0) and IF/ID (p1) registers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            pc_p0    <= RESET_PC;
            instr_p1 <= NOP_WORD;
            pc_p1    <= '0;
            vld_p1   <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            pc_p0    <= pc_p0_d;
            instr_p1 <= instr_p1_d;
            pc_p1    <= pc_p1_d;
            vld_p1   <= vld_p1_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_imem_addr   = pc_p0;
    assign o_instr       = instr_p1;
    assign o_pc          = pc_p1;
    assign o_pc_plus1    = pc_inc(pc_p1);
    assign o_valid       = vld_p1;
    assign o_halted      = (state_q == ST_HALT);
    assign o_fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [7:0]  tgt = 8'h00;
    logic [15:0] o_instr;
    logic [7:0]  o_pc;
    logic [7:0]  o_pc_plus1;
    logic        o_valid;
    logic        o_halted;
    logic [15:0] o_fetch_count;

    logic [15:0] imem [256];
    assign imem_data = imem[imem_addr];

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state (architectural view of the stage)
    logic [7:0]  m_pc;
    logic [7:0]  m_opc;
    logic [15:0] m_instr;
    logic        m_valid;
    logic        m_halted;
    logic [15:0] m_count;

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .o_imem_addr     (imem_addr),
        .i_imem_data     (imem_data),
        .i_stall         (stall),
        .i_branch_taken  (br),
        .i_branch_target (tgt),
        .o_instr         (o_instr),
        .o_pc            (o_pc),
        .o_pc_plus1      (o_pc_plus1),
        .o_valid         (o_valid),
        .o_halted        (o_halted),
        .o_fetch_count   (o_fetch_count)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic r, input logic s, input logic b, input logic [7:0] t);
        logic [15:0] w;
        if (r) begin
            m_pc = 8'h00; m_halted = 1'b0; m_instr = 16'hC000;
            m_opc = 8'h00; m_valid = 1'b0; m_count = 16'h0000;
        end else if (b) begin
            m_pc = t; m_halted = 1'b0; m_instr = 16'hC000; m_opc = 8'h00; m_valid = 1'b0;
        end else if (s) begin
            // everything holds
        end else if (m_halted) begin
            m_instr = 16'hC000; m_opc = 8'h00; m_valid = 1'b0;
        end else begin
            w = imem[m_pc];
            m_instr = w; m_opc = m_pc; m_valid = 1'b1;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            if (w[15:12] == 4'hF) m_halted = 1'b1;
            else m_pc = m_pc + 8'd1;
        end
    endtask

    task automatic cycle(input logic r, input logic s, input logic b, input logic [7:0] t);
        reset = r; stall = s; br = b; tgt = t;
        model_step(r, s, b, t);
        @(posedge clk);
        #1;
    endtask

    task automatic fill_imem();
        for (int k = 0; k < 256; k++) imem[k] = 16'(16'h2000 + k);
    endtask

    task automatic test_reset();
        fill_imem();
        cycle(1'b1, 1'b1, 1'b1, 8'h33);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if (o_instr !== 16'hC000) begin tests_failed++; $display("FAIL reset_instr got %h want c000", o_instr); end
        tests_run++;
        if (o_pc !== 8'h00 || o_valid !== 1'b0 || o_halted !== 1'b0) begin
            tests_failed++; $display("FAIL reset_ctrl got pc=%h v=%b h=%b want 00/0/0", o_pc, o_valid, o_halted);
        end
        tests_run++;
        if (o_fetch_count !== 16'h0000 || imem_addr !== 8'h00) begin
            tests_failed++; $display("FAIL reset_cnt_addr got cnt=%h addr=%h want 0000/00", o_fetch_count, imem_addr);
        end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 8'h00);
            tests_run++;
            if (o_instr !== 16'(16'h2000 + k) || o_pc !== 8'(k) || o_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL seq[%0d] got instr=%h pc=%h v=%b want %h/%h/1", k, o_instr, o_pc, o_valid,
                         16'(16'h2000 + k), 8'(k));
            end
        end
        tests_run++;
        if (o_fetch_count !== 16'd4 || imem_addr !== 8'h04) begin
            tests_failed++; $display("FAIL seq_count got cnt=%0d addr=%h want 4/04", o_fetch_count, imem_addr);
        end
    endtask

    task automatic test_stall_branch();
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h00);
            tests_run++;
            if (o_instr !== 16'h2002 || o_pc !== 8'h02 || imem_addr !== 8'h03 || o_fetch_count !== 16'd3) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d] got instr=%h pc=%h addr=%h cnt=%0d want 2002/02/03/3",
                         k, o_instr, o_pc, imem_addr, o_fetch_count);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if (o_instr !== 16'h2003 || o_pc !== 8'h03 || o_valid !== 1'b1) begin
            tests_failed++; $display("FAIL stall_resume got instr=%h pc=%h v=%b want 2003/03/1", o_instr, o_pc, o_valid);
        end
        cycle(1'b0, 1'b1, 1'b1, 8'h40);
        tests_run++;
        if (o_valid !== 1'b0 || o_instr !== 16'hC000 || imem_addr !== 8'h40) begin
            tests_failed++; $display("FAIL branch_bubble got v=%b instr=%h addr=%h want 0/c000/40", o_valid, o_instr, imem_addr);
        end
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if (o_pc !== 8'h40 || o_valid !== 1'b1 || o_instr !== 16'h2040) begin
            tests_failed++; $display("FAIL branch_target got pc=%h v=%b instr=%h want 40/1/2040", o_pc, o_valid, o_instr);
        end
    endtask

    task automatic test_halt();
        fill_imem();
        imem[5] = 16'hF000;
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if (o_instr !== 16'hF000 || o_pc !== 8'h05 || o_valid !== 1'b1 || o_halted !== 1'b1) begin
            tests_failed++;
            $display("FAIL halt_latch got instr=%h pc=%h v=%b h=%b want f000/05/1/1", o_instr, o_pc, o_valid, o_halted);
        end
        tests_run++;
        if (imem_addr !== 8'h05 || o_fetch_count !== 16'd6) begin
            tests_failed++; $display("FAIL halt_addr got addr=%h cnt=%0d want 05/6", imem_addr, o_fetch_count);
        end
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 8'h00);
            tests_run++;
            if (o_valid !== 1'b0 || o_halted !== 1'b1 || imem_addr !== 8'h05 || o_fetch_count !== 16'd6) begin
                tests_failed++;
                $display("FAIL halt_idle[%0d] got v=%b h=%b addr=%h cnt=%0d want 0/1/05/6",
                         k, o_valid, o_halted, imem_addr, o_fetch_count);
            end
        end
        cycle(1'b0, 1'b0, 1'b1, 8'h10);
        tests_run++;
        if (o_halted !== 1'b0 || o_valid !== 1'b0) begin
            tests_failed++; $display("FAIL halt_branch got h=%b v=%b want 0/0", o_halted, o_valid);
        end
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if (o_pc !== 8'h10 || o_valid !== 1'b1 || o_instr !== 16'h2010) begin
            tests_failed++; $display("FAIL halt_resume got pc=%h v=%b instr=%h want 10/1/2010", o_pc, o_valid, o_instr);
        end
        fill_imem();
    endtask

    task automatic test_wrap();
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 8'hFE);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if (o_pc !== 8'hFF || imem_addr !== 8'h00 || o_pc_plus1 !== 8'h00 || o_instr !== 16'h20FF) begin
            tests_failed++;
            $display("FAIL wrap got pc=%h addr=%h plus1=%h instr=%h want ff/00/00/20ff", o_pc, imem_addr, o_pc_plus1, o_instr);
        end
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if (o_pc !== 8'h00 || o_instr !== 16'h2000 || o_pc_plus1 !== 8'h01) begin
            tests_failed++; $display("FAIL wrap_next got pc=%h instr=%h plus1=%h want 00/2000/01", o_pc, o_instr, o_pc_plus1);
        end
    endtask

    task automatic test_reset_in_halt();
        imem[6] = 16'hF123;
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if (o_halted !== 1'b1 || o_fetch_count !== 16'd7) begin
            tests_failed++; $display("FAIL pre_reset got h=%b cnt=%0d want 1/7", o_halted, o_fetch_count);
        end
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if (o_halted !== 1'b0 || o_valid !== 1'b0 || o_fetch_count !== 16'd0 || imem_addr !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_in_halt got h=%b v=%b cnt=%0d addr=%h want 0/0/0/00", o_halted, o_valid, o_fetch_count, imem_addr);
        end
        fill_imem();
    endtask

    task automatic test_random();
        logic r, s, b;
        logic [7:0] t;
        for (int k = 0; k < 256; k++) imem[k] = 16'($urandom);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        for (int n = 0; n < 500; n++) begin
            r = ($urandom_range(0, 49) == 0);
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 9) == 0);
            t = 8'($urandom);
            cycle(r, s, b, t);
            tests_run++;
            if (o_instr !== m_instr || o_pc !== m_opc || o_valid !== m_valid || o_halted !== m_halted ||
                o_fetch_count !== m_count || imem_addr !== m_pc || o_pc_plus1 !== 8'(m_opc + 8'd1)) begin
                tests_failed++;
                $display("FAIL random[%0d] got instr=%h pc=%h v=%b h=%b cnt=%0d addr=%h p1=%h want %h/%h/%b/%b/%0d/%h/%h",
                         n, o_instr, o_pc, o_valid, o_halted, o_fetch_count, imem_addr, o_pc_plus1,
                         m_instr, m_opc, m_valid, m_halted, m_count, m_pc, 8'(m_opc + 8'd1));
            end
        end
        fill_imem();
    endtask

    task automatic test_saturation();
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        for (int n = 0; n < 65534; n++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if (o_fetch_count !== 16'hFFFE) begin
            tests_failed++; $display("FAIL sat_pre got %h want fffe", o_fetch_count);
        end
        for (int n = 0; n < 3; n++) begin
            cycle(1'b0, 1'b0, 1'b0, 8'h00);
            tests_run++;
            if (o_fetch_count !== 16'hFFFF) begin
                tests_failed++; $display("FAIL sat[%0d] got %h want ffff", n, o_fetch_count);
            end
        end
    endtask

    initial begin
        fill_imem();
        test_reset();
        test_sequential();
        test_stall_branch();
        test_halt();
        test_wrap();
        test_reset_in_halt();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
